// File: rtl/noc_output_port_arbiter.sv
// noc_output_port_arbiter: per-output-port switch/VC arbiter with wormhole
// ownership per downstream VC and downstream credit tracking.
// Optional statistics counters are built when NOC_ARB_STATS_EN is defined;
// otherwise the stat outputs are tied to zero.
module noc_output_port_arbiter #(
  parameter int unsigned PORT_NUM   = 5,
  parameter int unsigned VC_NUM     = 4,
  parameter int unsigned CREDIT_MAX = 4,
  parameter int unsigned VC_W       = $clog2(VC_NUM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORT_NUM-1:0]      req_valid,
  input  logic [PORT_NUM-1:0]      req_head,
  input  logic [PORT_NUM-1:0]      req_tail,
  input  logic [PORT_NUM*VC_W-1:0] req_vc,
  output logic [PORT_NUM-1:0]      gnt,
  output logic                     out_valid,
  output logic [PORT_NUM-1:0]      out_sel,
  output logic [VC_W-1:0]          out_vc,
  input  logic [VC_NUM-1:0]        credit_ret,
  output logic                     credit_err,
  output logic [PORT_NUM*16-1:0]   stat_gnt_cnt,
  output logic [15:0]              stat_block_cnt
);

  localparam int unsigned CRD_W = $clog2(CREDIT_MAX + 1);
  localparam int unsigned PTR_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  logic [CRD_W-1:0]    credit [VC_NUM];
  logic [VC_NUM-1:0]   lock;
  logic [PTR_W-1:0]    owner  [VC_NUM];
  logic [PTR_W-1:0]    rr_ptr;

  logic [VC_W-1:0]     vc_of  [PORT_NUM];
  logic [PORT_NUM-1:0] elig;
  logic                gnt_any;
  logic [PTR_W-1:0]    gnt_idx;
  logic [VC_W-1:0]     gnt_vc;
  logic [VC_NUM-1:0]   credit_dec;

  // Eligibility: credit available plus wormhole ownership rule per flit type
  always_comb begin
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      vc_of[p] = req_vc[p*VC_W +: VC_W];
      elig[p]  = 1'b0;
      if (req_valid[p] && (credit[vc_of[p]] != '0)) begin
        if (req_head[p])
          elig[p] = !lock[vc_of[p]];
        else
          elig[p] = lock[vc_of[p]] && (owner[vc_of[p]] == PTR_W'(p));
      end
    end
  end

  // Round-robin pick of the first eligible input at or after rr_ptr; rst gates it
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_vc  = '0;
    if (!rst) begin
      for (int unsigned off = 0; off < PORT_NUM; off++) begin
        idx = int'(rr_ptr) + off;
        if (idx >= PORT_NUM)
          idx = idx - PORT_NUM;
        if (!gnt_any && elig[idx]) begin
          gnt_any  = 1'b1;
          gnt[idx] = 1'b1;
          gnt_idx  = PTR_W'(idx);
          gnt_vc   = vc_of[idx];
        end
      end
    end
  end

  // Per-VC decrement strobe from the current grant
  always_comb begin
    for (int unsigned v = 0; v < VC_NUM; v++)
      credit_dec[v] = gnt_any && (gnt_vc == VC_W'(v));
  end

  // Credit, lock/owner and round-robin pointer state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        credit[v] <= CRD_W'(CREDIT_MAX);
        owner[v]  <= '0;
      end
      lock       <= '0;
      rr_ptr     <= '0;
      credit_err <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        case ({credit_dec[v], credit_ret[v]})
          2'b10: credit[v] <= credit[v] - 1'b1;
          2'b01: begin
            if (credit[v] == CRD_W'(CREDIT_MAX))
              credit_err <= 1'b1;
            else
              credit[v] <= credit[v] + 1'b1;
          end
          default: ;
        endcase
      end
      if (gnt_any) begin
        if (req_head[gnt_idx] && !req_tail[gnt_idx]) begin
          lock[gnt_vc]  <= 1'b1;
          owner[gnt_vc] <= gnt_idx;
        end else if (!req_head[gnt_idx] && req_tail[gnt_idx]) begin
          lock[gnt_vc] <= 1'b0;
        end
        rr_ptr <= (gnt_idx == PTR_W'(PORT_NUM - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // Registered copy of the grant that drives the crossbar next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sel   <= '0;
      out_vc    <= '0;
    end else begin
      out_valid <= gnt_any;
      out_sel   <= gnt;
      out_vc    <= gnt_vc;
    end
  end

`ifdef NOC_ARB_STATS_EN
  logic [15:0] gnt_cnt [PORT_NUM];
  logic [15:0] block_cnt;

  // Saturating grant and blocked-cycle counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned p = 0; p < PORT_NUM; p++)
        gnt_cnt[p] <= '0;
      block_cnt <= '0;
    end else begin
      for (int unsigned p = 0; p < PORT_NUM; p++)
        if (gnt[p] && (gnt_cnt[p] != '1))
          gnt_cnt[p] <= gnt_cnt[p] + 1'b1;
      if ((|req_valid) && !gnt_any && (block_cnt != '1))
        block_cnt <= block_cnt + 1'b1;
    end
  end

  // Pack per-input counters with input 0 at the LSB
  always_comb begin
    stat_gnt_cnt = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++)
      stat_gnt_cnt[p*16 +: 16] = gnt_cnt[p];
    stat_block_cnt = block_cnt;
  end
`else
  assign stat_gnt_cnt   = '0;
  assign stat_block_cnt = '0;
`endif

endmodule
